// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard unit for the five-stage MIPS core. Produces the
//            operand-forwarding selects and every stage stall/flush enable.
//            It also sequences multi-cycle divides and holds an exception
//            flush until the bus wait states have finished.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jrD,
    input  logic       div_startE,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       exceptM,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       div_doneE,
    output logic       exc_flush
);

    // Counter reload: BUSY lasts DIV_CYCLES cycles, counting down to zero.
    localparam logic [5:0] c_cnt_load = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t r_state;
    div_state_t w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic       r_pend;

    logic       w_wrM_ok;
    logic       w_wrW_ok;
    logic       w_wrE_ok;
    logic       w_lwstall;
    logic       w_brstall;
    logic       w_lstall;
    logic       w_divstall;

    // Destination qualifiers; register 0 is hard-wired and never a hazard.
    assign w_wrM_ok = regwriteM && (writeregM != 5'd0);
    assign w_wrW_ok = regwriteW && (writeregW != 5'd0);
    assign w_wrE_ok = regwriteE && (writeregE != 5'd0);

    // Forwarding selects: the M result beats the W result (it is newer).
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if (w_wrM_ok && (writeregM == rsE))      forwardaE = 2'b10;
        else if (w_wrW_ok && (writeregW == rsE)) forwardaE = 2'b01;
        if (w_wrM_ok && (writeregM == rtE))      forwardbE = 2'b10;
        else if (w_wrW_ok && (writeregW == rtE)) forwardbE = 2'b01;
    end

    assign forwardaD = w_wrM_ok && (writeregM == rsD);
    assign forwardbD = w_wrM_ok && (writeregM == rtD);

    // Load-use: a load in E cannot forward to D in time.
    assign w_lwstall = memtoregE && (writeregE != 5'd0)
                       && ((writeregE == rsD) || (writeregE == rtD));

    // Branch compare in D needs a value still being produced in E, or a
    // load result still in M.
    assign w_brstall = (branchD || jrD)
                       && ((w_wrE_ok && ((writeregE == rsD) || (writeregE == rtD)))
                        || (memtoregM && (writeregM != 5'd0)
                            && ((writeregM == rsD) || (writeregM == rtD))));

    assign w_lstall   = i_stall || d_stall;
    assign exc_flush  = (exceptM || r_pend) && !w_lstall;
    assign div_doneE  = (r_state == S_DONE);
    assign w_divstall = div_startE && (r_state != S_DONE);

    // Exception flush overrides every stall except a bus wait, and a bus
    // wait already blocks exc_flush, so masking with ~exc_flush is safe.
    assign stallF = (w_lwstall || w_brstall || w_divstall || w_lstall) && !exc_flush;
    assign stallD = stallF;
    assign stallE = (w_divstall || w_lstall) && !exc_flush;
    assign stallM = w_lstall;
    assign stallW = w_lstall;

    assign flushD = exc_flush;
    assign flushM = exc_flush;
    assign flushW = exc_flush;
    // Bubble into E only when E itself is advancing.
    assign flushE = exc_flush || ((w_lwstall || w_brstall) && !stallE);

    // Divider sequencer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (exc_flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_startE && !w_lstall) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 6'd0) w_state_nxt = S_DONE;
                    else               w_cnt_nxt   = r_cnt - 6'd1;
                end
                S_DONE: begin
                    if (!w_lstall) w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    // Divider state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Remember an exception that arrived during a bus wait until it can flush.
    always_ff @(posedge clk) begin
        if (rst)                        r_pend <= 1'b0;
        else if (exc_flush)             r_pend <= 1'b0;
        else if (exceptM && w_lstall)   r_pend <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed scenarios followed
//            by randomized traffic, against a behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, jrD, div_startE, i_stall, d_stall, exceptM;
    logic forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW, div_doneE, exc_flush;

    int checks = 0;
    int errors = 0;

    // Reference model state: divide in flight, cycles since it was accepted,
    // and a deferred exception.
    bit m_active;
    int m_age;
    bit m_pend;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(N)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .div_startE(div_startE),
        .i_stall(i_stall), .d_stall(d_stall), .exceptM(exceptM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_doneE(div_doneE), .exc_flush(exc_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, jrD, div_startE, i_stall, d_stall, exceptM} = '0;
    endtask

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
        if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bool_hit(input logic [4:0] dst);
        return (dst != 0) && (dst == rsD || dst == rtD);
    endfunction

    // Compare every output against the model for the current inputs/state.
    task automatic check_model(input string tag);
        bit ls, exc, lw, br, done, dv, sf, se, fe;
        #3;
        ls   = i_stall | d_stall;
        exc  = (exceptM | m_pend) & ~ls;
        lw   = memtoregE & bool_hit(writeregE);
        br   = (branchD | jrD) & ((regwriteE & bool_hit(writeregE)) | (memtoregM & bool_hit(writeregM)));
        done = m_active && (m_age >= N + 1);
        dv   = div_startE & ~done;
        sf   = exc ? 1'b0 : (lw | br | dv | ls);
        se   = exc ? 1'b0 : (dv | ls);
        fe   = exc | ((lw | br) & ~se);
        check({tag, ":fwd"}, {26'd0, forwardaD, forwardbD, forwardaE, forwardbE},
              {26'd0, regwriteM && writeregM != 0 && writeregM == rsD,
                      regwriteM && writeregM != 0 && writeregM == rtD, fwd_e(rsE), fwd_e(rtE)});
        check({tag, ":stall"}, {27'd0, stallF, stallD, stallE, stallM, stallW},
              {27'd0, sf, sf, se, ls, ls});
        check({tag, ":flush"}, {28'd0, flushD, flushE, flushM, flushW},
              {28'd0, exc, fe, exc, exc});
        check({tag, ":div_exc"}, {30'd0, div_doneE, exc_flush}, {30'd0, done, exc});
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit ls, exc, done;
        @(posedge clk);
        ls   = i_stall | d_stall;
        exc  = (exceptM | m_pend) & ~ls;
        done = m_active && (m_age >= N + 1);
        if (rst) begin
            m_active = 0; m_age = 0; m_pend = 0;
        end else begin
            if (exc) m_active = 0;
            else if (!m_active) begin
                if (div_startE && !ls) begin m_active = 1; m_age = 1; end
            end else if (done && !ls) m_active = 0;
            else m_age++;
            if (exc) m_pend = 0;
            else if (exceptM && ls) m_pend = 1;
        end
        #1;
    endtask

    task automatic step(input string tag);
        check_model(tag);
        tick();
    endtask

    initial begin
        zero_inputs();
        rst = 1'b1;
        m_active = 0; m_age = 0; m_pend = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state with idle inputs.
        check_model("reset");
        check("reset_all", {stallF, stallE, flushE, exc_flush, div_doneE, forwardaE}, 0);
        tick();

        // Load-use: lw r8 in E, add using r8 in D.
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8;
        check_model("lw");
        check("lw_stall", {stallF, stallD, flushE, stallE}, 4'b1110);
        tick();
        zero_inputs(); regwriteM = 1; memtoregM = 1; writeregM = 8; rsE = 8;
        check_model("lw_fwd");
        check("lw_fwdaE", forwardaE, 2'b10);
        tick();

        // r0 never forwarded; M beats W.
        zero_inputs(); regwriteM = 1; writeregM = 0; rsE = 0;
        step("r0");
        regwriteM = 1; regwriteW = 1; writeregM = 5; writeregW = 5; rsE = 5;
        check_model("prio");
        check("prio_fwdaE", forwardaE, 2'b10);
        tick();

        // Branch on r3 produced in E, then forwarded from M.
        zero_inputs(); branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        check_model("br");
        check("br_stall", {stallD, flushE}, 2'b11);
        tick();
        zero_inputs(); branchD = 1; rsD = 3; regwriteM = 1; writeregM = 3;
        check_model("br_fwd");
        check("br_fwdaD", {forwardaD, stallD}, 2'b10);
        tick();

        // Divide: stallE for N+1 cycles, then one cycle of div_doneE.
        zero_inputs(); div_startE = 1;
        for (int i = 0; i < N + 2; i++) begin
            check_model("div");
            check("div_seq", {stallE, div_doneE}, (i <= N) ? 2'b10 : 2'b01);
            tick();
        end
        div_startE = 0;
        step("div_idle");

        // Exception during a divide kills it.
        div_startE = 1;
        step("dx0"); step("dx1");
        exceptM = 1;
        check_model("dx_exc");
        check("dx_flush", {exc_flush, stallE}, 2'b10);
        tick();
        zero_inputs();
        check_model("dx_after");
        check("dx_idle", div_doneE, 1'b0);
        tick();

        // Exception deferred across a 3-cycle data stall.
        exceptM = 1; d_stall = 1;
        for (int i = 0; i < 3; i++) begin
            check_model("defer");
            check("defer_noflush", exc_flush, 1'b0);
            tick();
        end
        zero_inputs();
        check_model("defer_rel");
        check("defer_flush", {flushD, flushE, flushM, flushW}, 4'hF);
        tick();
        check_model("defer_clr");
        check("defer_once", exc_flush, 1'b0);
        tick();

        // Reset while dividing with an exception pending.
        div_startE = 1; step("rb0");
        div_startE = 0; exceptM = 1; d_stall = 1; step("rb1");
        exceptM = 0; rst = 1; tick();
        rst = 0; d_stall = 0;
        check_model("rst_mid");
        check("rst_mid_clear", {exc_flush, div_doneE, stallE, flushE}, 0);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
            writeregE = 5'($urandom_range(0, 7));
            writeregM = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1)); memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0); branchD = ($urandom_range(0, 3) == 0);
            jrD = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) div_startE = ~div_startE;
            i_stall = ($urandom_range(0, 7) == 0); d_stall = ($urandom_range(0, 5) == 0);
            exceptM = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
